// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register block: register numbers, exception codes,
// Status/Cause field positions, reset values and MTC0 write masks.
package cp0_pkg;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;
   localparam logic [4:0] REG_CONFIG   = 5'd16;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_SYS  = 5'd8,
      EXC_BP   = 5'd9,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12,
      EXC_TR   = 5'd13
   } exc_code_e;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_LO  = 8;
   localparam int CA_EXC_LO = 2;
   localparam int CA_IP_LO  = 8;
   localparam int CA_HW_LO  = 10;
   localparam int CA_TI     = 30;
   localparam int CA_BD     = 31;

   localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

endpackage

// File: rtl/cp0_if.sv
// Bus between the pipeline (MFC0/MTC0, exception/ERET commit) and the CP0 block.
interface cp0_if #(parameter int HW_INT_NUM = 6);
   logic                  we_i;
   logic [4:0]            waddr_i;
   logic [31:0]           wdata_i;
   logic [4:0]            raddr_i;
   logic [31:0]           rdata_o;
   logic [HW_INT_NUM-1:0] hw_int_i;
   logic                  exc_valid_i;
   logic [4:0]            exc_code_i;
   logic [31:0]           exc_pc_i;
   logic                  exc_bd_i;
   logic [31:0]           exc_badvaddr_i;
   logic                  eret_i;
   logic [31:0]           status_o;
   logic [31:0]           cause_o;
   logic [31:0]           epc_o;
   logic                  int_req_o;
   logic                  timer_int_o;

   modport master (
      output we_i, waddr_i, wdata_i, raddr_i, hw_int_i, exc_valid_i, exc_code_i,
             exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
      input  rdata_o, status_o, cause_o, epc_o, int_req_o, timer_int_o
   );

   modport slave (
      input  we_i, waddr_i, wdata_i, raddr_i, hw_int_i, exc_valid_i, exc_code_i,
             exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
      output rdata_o, status_o, cause_o, epc_o, int_req_o, timer_int_o
   );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with a programmable prescaler; ti latches on Count==Compare
// and is cleared only by a Compare write.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic [31:0] count_wdata,
   input  logic        compare_we,
   input  logic [31:0] compare_wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam logic [3:0] LAST = 4'(COUNT_DIV - 1);

   logic [3:0] phase;
   logic       tick;

   assign tick = (phase == LAST);

   // A Count write restarts the prescaler so the new value holds a full period.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase <= '0;
         count <= '0;
      end else if (count_we) begin
         phase <= '0;
         count <= count_wdata;
      end else if (tick) begin
         phase <= '0;
         count <= count + 32'd1;
      end else begin
         phase <= phase + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         compare <= '0;
         ti      <= 1'b0;
      end else if (compare_we) begin
         compare <= compare_wdata;
         ti      <= 1'b0;
      end else if (count == compare) begin
         ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register block (BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config).
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0 and TI is 0.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
   input logic  clk,
   input logic  resetn,
   cp0_if.slave bus
);

   logic [31:0]           status_q;
   logic [31:0]           epc_q;
   logic [31:0]           badvaddr_q;
   logic [1:0]            ip_sw_q;
   logic [HW_INT_NUM-1:0] ip_hw_q;
   logic                  bd_q;
   logic [4:0]            exc_code_q;

   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;
   logic [7:0]  ip;
   logic [31:0] cause;
   logic        mtc0_ok;

   // Exception and ERET both pre-empt MTC0 to Status/Cause/EPC.
   assign mtc0_ok = bus.we_i & ~bus.exc_valid_i & ~bus.eret_i;

`ifdef CP0_TIMER_EN
   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk          (clk),
      .resetn       (resetn),
      .count_we     (bus.we_i && bus.waddr_i == REG_COUNT),
      .count_wdata  (bus.wdata_i),
      .compare_we   (bus.we_i && bus.waddr_i == REG_COMPARE),
      .compare_wdata(bus.wdata_i),
      .count        (count),
      .compare      (compare),
      .ti           (ti)
   );
`else
   assign count   = '0;
   assign compare = '0;
   assign ti      = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_q <= STATUS_RST;
      end else if (bus.exc_valid_i) begin
         status_q[ST_EXL] <= 1'b1;
      end else if (bus.eret_i) begin
         status_q[ST_EXL] <= 1'b0;
      end else if (mtc0_ok && bus.waddr_i == REG_STATUS) begin
         status_q <= (status_q & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
      end
   end

   // EPC/BD capture only the outermost exception; nested ones keep the original return point.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         epc_q      <= '0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         ip_sw_q    <= '0;
      end else if (bus.exc_valid_i) begin
         exc_code_q <= bus.exc_code_i;
         if (!status_q[ST_EXL]) begin
            epc_q <= bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
            bd_q  <= bus.exc_bd_i;
         end
      end else if (mtc0_ok && bus.waddr_i == REG_EPC) begin
         epc_q <= bus.wdata_i;
      end else if (mtc0_ok && bus.waddr_i == REG_CAUSE) begin
         ip_sw_q <= bus.wdata_i[CA_IP_LO +: 2];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badvaddr_q <= '0;
         ip_hw_q    <= '0;
      end else begin
         ip_hw_q <= bus.hw_int_i;
         if (bus.exc_valid_i && (bus.exc_code_i == EXC_ADEL || bus.exc_code_i == EXC_ADES))
            badvaddr_q <= bus.exc_badvaddr_i;
      end
   end

   always_comb begin
      ip                  = '0;
      ip[1:0]             = ip_sw_q;
      ip[2 +: HW_INT_NUM] = ip_hw_q;
      ip[7]               = ip[7] | ti;
   end

   always_comb begin
      cause                       = '0;
      cause[CA_BD]                = bd_q;
      cause[CA_TI]                = ti;
      cause[CA_IP_LO +: 8]        = ip;
      cause[CA_EXC_LO +: 5]       = exc_code_q;
   end

   always_comb begin
      bus.rdata_o = '0;
      case (bus.raddr_i)
         REG_BADVADDR: bus.rdata_o = badvaddr_q;
         REG_COUNT:    bus.rdata_o = count;
         REG_COMPARE:  bus.rdata_o = compare;
         REG_STATUS:   bus.rdata_o = status_q;
         REG_CAUSE:    bus.rdata_o = cause;
         REG_EPC:      bus.rdata_o = epc_q;
         REG_PRID:     bus.rdata_o = PRID_VAL;
         REG_CONFIG:   bus.rdata_o = CONFIG_VAL;
         default:      bus.rdata_o = '0;
      endcase
   end

   assign bus.status_o    = status_q;
   assign bus.cause_o     = cause;
   assign bus.epc_o       = epc_q;
   assign bus.timer_int_o = ti;
   assign bus.int_req_o   = (|(ip & status_q[ST_IM_LO +: 8])) & status_q[ST_IE] & ~status_q[ST_EXL];

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: field-level reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_cp0_unit;

   localparam int HW  = 6;
   localparam int DIV = 2;

   logic clk;
   logic resetn;
   bit   chk_en;
   int   n_chk;
   int   n_err;

   cp0_if #(.HW_INT_NUM(HW)) bus ();

   cp0_unit #(
      .HW_INT_NUM(HW),
      .COUNT_DIV (DIV),
      .PRID_VAL  (32'h004C_0102),
      .CONFIG_VAL(32'h0000_8000)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model kept as architectural fields; Count is base + elapsed/DIV.
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti;
   logic [4:0]  m_code;
   logic [1:0]  m_sw;
   logic [HW-1:0] m_hw;
   logic [31:0] m_epc, m_bad, m_base, m_cmp;
   int unsigned m_elapsed;

   function automatic logic [31:0] mc_count();
`ifdef CP0_TIMER_EN
      return m_base + 32'(m_elapsed / DIV);
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] mc_cmp();
`ifdef CP0_TIMER_EN
      return m_cmp;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic mc_ti();
`ifdef CP0_TIMER_EN
      return m_ti;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_status();
      return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
   endfunction

   function automatic logic [7:0] exp_ip();
      logic [7:0] ip;
      ip = {2'b00, m_hw} << 2;
      ip[1:0] = m_sw;
      ip[7] = ip[7] | mc_ti();
      return ip;
   endfunction

   function automatic logic [31:0] exp_cause();
      return {m_bd, mc_ti(), 14'd0, exp_ip(), 1'b0, m_code, 2'b00};
   endfunction

   function automatic logic exp_int_req();
      return (|(exp_ip() & m_im)) && m_ie && !m_exl;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      case (a)
         5'd8:    return m_bad;
         5'd9:    return mc_count();
         5'd11:   return mc_cmp();
         5'd12:   return exp_status();
         5'd13:   return exp_cause();
         5'd14:   return m_epc;
         5'd15:   return 32'h004C_0102;
         5'd16:   return 32'h0000_8000;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_im <= '0; m_exl <= 1'b0; m_ie <= 1'b0; m_bd <= 1'b0; m_ti <= 1'b0;
         m_code <= '0; m_sw <= '0; m_hw <= '0; m_epc <= '0; m_bad <= '0;
         m_base <= '0; m_cmp <= '0; m_elapsed <= 0;
      end else begin
         m_hw <= bus.hw_int_i;
         if (bus.we_i && bus.waddr_i == 5'd9) begin
            m_base <= bus.wdata_i;
            m_elapsed <= 0;
         end else begin
            m_elapsed <= m_elapsed + 1;
         end
         if (bus.we_i && bus.waddr_i == 5'd11) begin
            m_cmp <= bus.wdata_i;
            m_ti <= 1'b0;
         end else if (mc_count() == m_cmp) begin
            m_ti <= 1'b1;
         end
         if (bus.exc_valid_i) begin
            m_code <= bus.exc_code_i;
            m_exl <= 1'b1;
            if (!m_exl) begin
               m_epc <= bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
               m_bd <= bus.exc_bd_i;
            end
            if (bus.exc_code_i == 5'd4 || bus.exc_code_i == 5'd5) m_bad <= bus.exc_badvaddr_i;
         end else if (bus.eret_i) begin
            m_exl <= 1'b0;
         end else if (bus.we_i) begin
            case (bus.waddr_i)
               5'd12: begin m_im <= bus.wdata_i[15:8]; m_exl <= bus.wdata_i[1]; m_ie <= bus.wdata_i[0]; end
               5'd13: m_sw <= bus.wdata_i[9:8];
               5'd14: m_epc <= bus.wdata_i;
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("status_o", bus.status_o, exp_status());
         chk("cause_o", bus.cause_o, exp_cause());
         chk("epc_o", bus.epc_o, m_epc);
         chk("int_req_o", 32'(bus.int_req_o), 32'(exp_int_req()));
         chk("timer_int_o", 32'(bus.timer_int_o), 32'(mc_ti()));
         chk("rdata_o", bus.rdata_o, exp_rd(bus.raddr_i));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
      cyc();
      bus.we_i = 1'b0;
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic [31:0] bad);
      bus.exc_valid_i = 1'b1; bus.exc_code_i = code; bus.exc_pc_i = pc;
      bus.exc_bd_i = bd; bus.exc_badvaddr_i = bad;
      cyc();
      bus.exc_valid_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_err = 0; chk_en = 0;
      resetn = 1'b1;
      bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.raddr_i = 0; bus.hw_int_i = '0;
      bus.exc_valid_i = 0; bus.exc_code_i = 0; bus.exc_pc_i = 0; bus.exc_bd_i = 0;
      bus.exc_badvaddr_i = 0; bus.eret_i = 0;
      #1 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      chk_en = 1;

      // dirty the state, then an asynchronous mid-cycle reset
      bus.raddr_i = 5'd12;
      mtc0(5'd12, 32'hFFFF_FFFF);
      chk("status_mask", bus.rdata_o, 32'h0040_FF03);
      mtc0(5'd14, 32'h1234_5678);
      mtc0(5'd13, 32'hFFFF_FFFF);
      #1 resetn = 1'b0;
      #1;
      chk("rst_status", bus.status_o, 32'h0040_0000);
      chk("rst_cause", bus.cause_o, 32'h0);
      chk("rst_epc", bus.epc_o, 32'h0);
      chk("rst_int_req", 32'(bus.int_req_o), 32'd0);
      chk("rst_rdata", bus.rdata_o, 32'h0040_0000);
      @(posedge clk);
      #2 resetn = 1'b1;

      // timer
      bus.raddr_i = 5'd9;
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      repeat (9) cyc();
`ifdef CP0_TIMER_EN
      chk("count_at_10", bus.rdata_o, 32'd5);
      chk("ti_before", 32'(bus.timer_int_o), 32'd0);
      cyc();
      chk("ti_set", 32'(bus.timer_int_o), 32'd1);
      chk("cause_ti", 32'(bus.cause_o[30]), 32'd1);
      mtc0(5'd11, 32'd100);
      chk("ti_clear", 32'(bus.timer_int_o), 32'd0);
`else
      chk("count_off", bus.rdata_o, 32'd0);
      cyc();
      chk("ti_off", 32'(bus.timer_int_o), 32'd0);
      mtc0(5'd11, 32'd100);
      bus.raddr_i = 5'd11;
      #1 chk("compare_off", bus.rdata_o, 32'd0);
`endif

      // delay-slot exception then nested address error
      exc(5'd12, 32'hBFC0_0104, 1'b1, 32'h0);
      chk("ds_epc", bus.epc_o, 32'hBFC0_0100);
      chk("ds_bd", 32'(bus.cause_o[31]), 32'd1);
      chk("ds_code", 32'(bus.cause_o[6:2]), 32'd12);
      chk("ds_exl", 32'(bus.status_o[1]), 32'd1);
      bus.raddr_i = 5'd8;
      exc(5'd4, 32'h0000_2000, 1'b0, 32'h0000_0003);
      chk("nest_epc", bus.epc_o, 32'hBFC0_0100);
      chk("nest_code", 32'(bus.cause_o[6:2]), 32'd4);
      chk("nest_bd", 32'(bus.cause_o[31]), 32'd1);
      chk("nest_badv", bus.rdata_o, 32'h0000_0003);

      // interrupt request
      bus.eret_i = 1'b1; cyc(); bus.eret_i = 1'b0;
      mtc0(5'd12, 32'h0000_0401);
      bus.hw_int_i = 6'b000001;
      #1 chk("irq_unsampled", 32'(bus.int_req_o), 32'd0);
      cyc();
      chk("irq_set", 32'(bus.int_req_o), 32'd1);
      mtc0(5'd12, 32'h0000_0403);
      chk("irq_exl_mask", 32'(bus.int_req_o), 32'd0);

      // ERET beats MTC0 Status
      bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'h0; bus.eret_i = 1'b1;
      cyc();
      bus.we_i = 1'b0; bus.eret_i = 1'b0;
      chk("eret_prio", bus.status_o, 32'h0040_0401);
      chk("eret_irq", 32'(bus.int_req_o), 32'd1);

      // exception with same-cycle MTC0 Count: Count write survives
      bus.raddr_i = 5'd9;
      bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'h77;
      bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd8; bus.exc_pc_i = 32'h100; bus.exc_bd_i = 1'b0;
      cyc();
      bus.we_i = 1'b0; bus.exc_valid_i = 1'b0;
`ifdef CP0_TIMER_EN
      chk("count_vs_exc", bus.rdata_o, 32'h77);
`else
      chk("count_vs_exc", bus.rdata_o, 32'h0);
`endif
      chk("exc_epc", bus.epc_o, 32'h100);
      chk("exc_code8", 32'(bus.cause_o[6:2]), 32'd8);

      // write masks, read-only and unmapped registers
      mtc0(5'd13, 32'hFFFF_FFFF);
      chk("cause_sw_ip", 32'(bus.cause_o[9:8]), 32'd3);
      chk("cause_code_kept", 32'(bus.cause_o[6:2]), 32'd8);
      mtc0(5'd3, 32'hDEAD_BEEF);
      bus.raddr_i = 5'd3;
      #1 chk("unmapped", bus.rdata_o, 32'h0);
      mtc0(5'd15, 32'h0);
      bus.raddr_i = 5'd15;
      #1 chk("prid", bus.rdata_o, 32'h004C_0102);
      bus.raddr_i = 5'd16;
      #1 chk("config", bus.rdata_o, 32'h0000_8000);
      mtc0(5'd8, 32'hFFFF_FFFF);
      bus.raddr_i = 5'd8;
      #1 chk("badv_ro", bus.rdata_o, 32'h0000_0003);

      // Count wrap and Compare=0 match
      bus.raddr_i = 5'd9;
      mtc0(5'd9, 32'hFFFF_FFFE);
      mtc0(5'd11, 32'h0);
      repeat (8) cyc();

      // read sweep and interrupt line patterns
      for (int a = 0; a < 18; a++) begin
         bus.raddr_i = 5'(a);
         bus.hw_int_i = 6'(a * 11);
         cyc();
      end
      mtc0(5'd12, 32'h0000_FC01);
      for (int k = 0; k < 8; k++) begin
         bus.hw_int_i = 6'(1 << (k % 6));
         bus.raddr_i = 5'd13;
         cyc();
      end
      bus.hw_int_i = '0;
      cyc();

      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
